// File: rtl/tappy_pkg.sv
// Shared types and constants for the tappy_rx PS/2-style serial receiver.
package tappy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic START_LEVEL     = 1'b0;
    localparam logic STOP_LEVEL      = 1'b1;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/tappy_sync.sv
// Multi-stage input synchronizer with a falling-edge detector on the synchronized level.
module tappy_sync #(
    parameter int STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);

    // Fewer than two stages would not resolve metastability, so clamp.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_r;
    logic         prev_r;

    // Shift chain and edge-history flop; reset high to match the idle line.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_r <= '1;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[N-2:0], din};
            prev_r <= sync_r[N-1];
        end
    end

    assign level = sync_r[N-1];
    assign fall  = prev_r & ~sync_r[N-1];

endmodule

// File: rtl/tappy_rx.sv
// Top of the PS/2-style receiver: synchronizes clk/dat, runs the frame FSM and publishes bytes.
module tappy_rx
    import tappy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       dat,
    input  logic                       inhibit,
    output logic [FRAME_DATA_BITS-1:0] word,
    output logic                       done
);

    localparam int CW = $clog2(FRAME_DATA_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_level_s;
    logic clk_fall_s;
    logic dat_level_s;
    logic dat_fall_s;
    logic unused_s;

    state_t                     state_r,  state_nxt_s;
    logic [CW-1:0]              count_r,  count_nxt_s;
    logic [FRAME_DATA_BITS-1:0] shift_r,  shift_nxt_s;
    logic                       parity_r, parity_nxt_s;
    logic [TW-1:0]              timer_r,  timer_nxt_s;
    logic [FRAME_DATA_BITS-1:0] word_r,   word_nxt_s;
    logic                       done_r,   done_nxt_s;

    tappy_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .din    (clk),
        .level  (clk_level_s),
        .fall   (clk_fall_s)
    );

    tappy_sync #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .din    (dat),
        .level  (dat_level_s),
        .fall   (dat_fall_s)
    );

    // Only the clk edge and the dat level are consumed.
    assign unused_s = clk_level_s ^ dat_fall_s;

    // State and datapath registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            shift_r  <= '0;
            parity_r <= 1'b0;
            timer_r  <= '0;
            word_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            shift_r  <= shift_nxt_s;
            parity_r <= parity_nxt_s;
            timer_r  <= timer_nxt_s;
            word_r   <= word_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Next-state logic: inhibit beats a sample, and a sample beats the timeout.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        shift_nxt_s  = shift_r;
        parity_nxt_s = parity_r;
        timer_nxt_s  = timer_r;
        word_nxt_s   = word_r;
        done_nxt_s   = 1'b0;

        if (inhibit) begin
            state_nxt_s  = ST_IDLE;
            count_nxt_s  = '0;
            shift_nxt_s  = '0;
            parity_nxt_s = 1'b0;
            timer_nxt_s  = '0;
        end else if (clk_fall_s) begin
            timer_nxt_s = '0;
            case (state_r)
                ST_IDLE: begin
                    if (dat_level_s == START_LEVEL) begin
                        state_nxt_s = ST_DATA;
                        count_nxt_s = '0;
                        shift_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s[count_r] = dat_level_s;
                    count_nxt_s          = count_r + CW'(1);
                    if (count_r == CW'(FRAME_DATA_BITS - 1)) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_nxt_s = dat_level_s;
                    state_nxt_s  = ST_STOP;
                end
                ST_STOP: begin
                    if ((dat_level_s == STOP_LEVEL) && odd_parity_ok(shift_r, parity_r)) begin
                        word_nxt_s = shift_r;
                        done_nxt_s = 1'b1;
                    end else begin
                        word_nxt_s = word_r;
                    end
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = '0;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = '0;
                end
            endcase
        end else if (state_r != ST_IDLE) begin
            if ((timer_r + TW'(1)) == TW'(TIMEOUT_CYCLES)) begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = '0;
                shift_nxt_s = '0;
                timer_nxt_s = '0;
            end else begin
                timer_nxt_s = timer_r + TW'(1);
            end
        end else begin
            timer_nxt_s = '0;
        end
    end

    assign word = word_r;
    assign done = done_r;

endmodule

// File: tb/tb_tappy_rx.sv
// Directed self-checking bench for tappy_rx: good, corrupt, timed-out, inhibited and reset frames.
module tb_tappy_rx;

    localparam int SLOW_HALF = 12;   // 24 sysclk cycles per link bit
    localparam int FAST_HALF = 7;    // 14 sysclk cycles per link bit

    logic       sysclk;
    logic       reset;
    logic       clk;
    logic       dat;
    logic       inhibit;
    logic [7:0] word;
    logic       done;

    int total;
    int bad;
    int done_cnt;
    int c0;
    int early;

    tappy_rx #(.TIMEOUT_CYCLES(32), .SYNC_STAGES(2)) tappy (
        .sysclk  (sysclk),
        .reset   (reset),
        .clk     (clk),
        .dat     (dat),
        .inhibit (inhibit),
        .word    (word),
        .done    (done)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Counts every sysclk cycle in which done is high, so a stretched pulse counts twice.
    always @(negedge sysclk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends nbits of a frame; par_flip corrupts parity, inh_at raises inhibit before that bit.
    task automatic send_frame(input logic [7:0] b, input int half, input logic par_flip,
                              input logic stop_val, input int nbits, input int inh_at,
                              output int lat_cnt);
        logic [10:0] fr;
        int          d0;
        fr      = {stop_val, (~^b) ^ par_flip, b, 1'b0};
        lat_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == inh_at) inhibit = 1'b1;
            dat = fr[i];
            tick(half);
            clk = 1'b0;
            if (i == 10) begin
                d0 = done_cnt;
                repeat (4) @(posedge sysclk);
                @(negedge sysclk);
                #1;
                lat_cnt = done_cnt - d0;
                tick(half - 4);
            end else begin
                tick(half);
            end
            clk = 1'b1;
        end
        dat     = 1'b1;
        inhibit = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        reset    = 1'b0;
        clk      = 1'b1;
        dat      = 1'b1;
        inhibit  = 1'b0;
        #2;
        check("reset_word", {24'h0, word}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        tick(3);
        reset = 1'b1;
        tick(5);

        // 0xA5 at the slow rate, with the latency bound measured on the stop edge.
        c0 = done_cnt;
        send_frame(8'hA5, SLOW_HALF, 1'b0, 1'b1, 11, 99, early);
        check("a5_latency", early, 32'd1);
        check("a5_word", {24'h0, word}, 32'hA5);
        check("a5_done_pulses", done_cnt - c0, 32'd1);

        // Back-to-back frames at the fast rate.
        c0 = done_cnt;
        send_frame(8'h00, FAST_HALF, 1'b0, 1'b1, 11, 99, early);
        check("b2b_00", {24'h0, word}, 32'h00);
        send_frame(8'hFF, FAST_HALF, 1'b0, 1'b1, 11, 99, early);
        check("b2b_ff", {24'h0, word}, 32'hFF);
        send_frame(8'h01, FAST_HALF, 1'b0, 1'b1, 11, 99, early);
        check("b2b_01", {24'h0, word}, 32'h01);
        send_frame(8'h80, FAST_HALF, 1'b0, 1'b1, 11, 99, early);
        check("b2b_80", {24'h0, word}, 32'h80);
        check("b2b_done_pulses", done_cnt - c0, 32'd4);

        // Parity error, then a good frame.
        c0 = done_cnt;
        send_frame(8'h3C, SLOW_HALF, 1'b1, 1'b1, 11, 99, early);
        check("par_err_no_done", done_cnt - c0, 32'd0);
        check("par_err_word_kept", {24'h0, word}, 32'h80);
        send_frame(8'h42, SLOW_HALF, 1'b0, 1'b1, 11, 99, early);
        check("after_par_word", {24'h0, word}, 32'h42);
        check("after_par_done", done_cnt - c0, 32'd1);

        // Stop bit low.
        c0 = done_cnt;
        send_frame(8'h55, SLOW_HALF, 1'b0, 1'b0, 11, 99, early);
        check("stop_err_no_done", done_cnt - c0, 32'd0);
        check("stop_err_word_kept", {24'h0, word}, 32'h42);

        // Frame abandoned after start + 4 data bits, then idle past the timeout.
        c0 = done_cnt;
        send_frame(8'hE7, SLOW_HALF, 1'b0, 1'b1, 5, 99, early);
        tick(60);
        check("timeout_no_done", done_cnt - c0, 32'd0);
        send_frame(8'h12, SLOW_HALF, 1'b0, 1'b1, 11, 99, early);
        check("after_timeout_word", {24'h0, word}, 32'h12);
        check("after_timeout_done", done_cnt - c0, 32'd1);

        // Inhibit raised mid-frame and held to its end.
        c0 = done_cnt;
        send_frame(8'h77, SLOW_HALF, 1'b0, 1'b1, 11, 5, early);
        check("inhibit_no_done", done_cnt - c0, 32'd0);
        check("inhibit_word_kept", {24'h0, word}, 32'h12);
        tick(4);
        send_frame(8'h78, SLOW_HALF, 1'b0, 1'b1, 11, 99, early);
        check("after_inhibit_word", {24'h0, word}, 32'h78);
        check("after_inhibit_done", done_cnt - c0, 32'd1);

        // Reset pulsed in the middle of a frame.
        send_frame(8'hC3, SLOW_HALF, 1'b0, 1'b1, 6, 99, early);
        reset = 1'b0;
        #1;
        check("midreset_word", {24'h0, word}, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        tick(3);
        reset = 1'b1;
        tick(5);
        c0 = done_cnt;
        send_frame(8'h9A, SLOW_HALF, 1'b0, 1'b1, 11, 99, early);
        check("after_reset_word", {24'h0, word}, 32'h9A);
        check("after_reset_done", done_cnt - c0, 32'd1);

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
